aes_round_sequencer: RTL and testbench

Parametrised successor to the AES-128 controller. Sequences key expansion and cipher rounds for AES-128/192/256 in both encrypt and decrypt directions, drives one sub-unit enable at a time over a level/finished handshake, and adds a per-step watchdog plus abort. Sits between the AHB slave front end (start/mode) and the key-expansion, SubBytes, ShiftRows, MixColumns and AddRoundKey datapath units.

---
 rtl/aes_round_sequencer_if.sv | 39 +++
 rtl/aes_round_sequencer.sv | 168 ++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sequencer_if.sv
// Control bundle between the AES round sequencer, its front end and the datapath units.
// The master side drives start/mode and the unit finished flags; the slave side is the sequencer.
interface aes_round_sequencer_if #(
  parameter int ROUND_W = 4
) ();
  logic               start;
  logic               abort;
  logic [1:0]         key_mode;
  logic               decrypt;
  logic               keyexp_finished;
  logic               sbytes_finished;
  logic               srows_finished;
  logic               mcol_finished;
  logic               around_finished;
  logic               keyexp_enable;
  logic               sbytes_enable;
  logic               srows_enable;
  logic               mcol_enable;
  logic               around_enable;
  logic               inv;
  logic [ROUND_W-1:0] roundnum;
  logic               busy;
  logic               done;
  logic               error;

  modport master (
    output start, abort, key_mode, decrypt,
    output keyexp_finished, sbytes_finished, srows_finished, mcol_finished, around_finished,
    input  keyexp_enable, sbytes_enable, srows_enable, mcol_enable, around_enable,
    input  inv, roundnum, busy, done, error
  );

  modport slave (
    input  start, abort, key_mode, decrypt,
    input  keyexp_finished, sbytes_finished, srows_finished, mcol_finished, around_finished,
    output keyexp_enable, sbytes_enable, srows_enable, mcol_enable, around_enable,
    output inv, roundnum, busy, done, error
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Sequences AES-128/192/256 key expansion and cipher/inverse-cipher rounds,
// one datapath unit at a time, with a per-step watchdog and abort.
module aes_round_sequencer #(
  parameter int ROUND_W     = 4,
  parameter bit SUPPORT_256 = 1'b1,
  parameter int TIMEOUT     = 255
) (
  input logic                  clk,
  input logic                  rst,
  aes_round_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, KEYEXP, SB, SR, MC, ARK, DONE, ERROR} state_t;

  localparam int               CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wd_cnt, wd_cnt_nxt;
  logic [ROUND_W-1:0] round, round_nxt;
  logic [ROUND_W-1:0] nr, nr_nxt;
  logic               inv, inv_nxt;
  logic               error, error_nxt;
  logic               step_fin;
  logic               mode_ok;

  function automatic logic [ROUND_W-1:0] rounds_for(input logic [1:0] mode);
    case (mode)
      2'b00:   return ROUND_W'(10);
      2'b01:   return ROUND_W'(12);
      default: return ROUND_W'(14);
    endcase
  endfunction

  assign mode_ok = (bus.key_mode == 2'b00) || (bus.key_mode == 2'b01) ||
                   ((bus.key_mode == 2'b10) && SUPPORT_256);

  // Only the finished of the unit owning the current step is honoured.
  always_comb begin
    step_fin = 1'b0;
    case (state)
      KEYEXP:  step_fin = bus.keyexp_finished;
      SB:      step_fin = bus.sbytes_finished;
      SR:      step_fin = bus.srows_finished;
      MC:      step_fin = bus.mcol_finished;
      ARK:     step_fin = bus.around_finished;
      default: step_fin = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    wd_cnt_nxt = wd_cnt;
    round_nxt  = round;
    nr_nxt     = nr;
    inv_nxt    = inv;
    error_nxt  = error;
    if (bus.abort) begin
      state_nxt  = IDLE;
      round_nxt  = '0;
      wd_cnt_nxt = '0;
      error_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (state == DONE) state_nxt = IDLE;
          if (bus.start) begin
            round_nxt = '0;
            if (mode_ok) begin
              state_nxt  = KEYEXP;
              nr_nxt     = rounds_for(bus.key_mode);
              inv_nxt    = bus.decrypt;
              error_nxt  = 1'b0;
              wd_cnt_nxt = '0;
            end else begin
              state_nxt = IDLE;
              error_nxt = 1'b1;
            end
          end
        end
        default: begin
          if (step_fin) begin
            wd_cnt_nxt = '0;
            // Encrypt bumps the round on entry to SB, decrypt drops it on entry to SR.
            case (state)
              KEYEXP: begin
                state_nxt = ARK;
                round_nxt = inv ? nr : '0;
              end
              SB: state_nxt = inv ? ARK : SR;
              SR: begin
                if (inv)              state_nxt = SB;
                else if (round == nr) state_nxt = ARK;
                else                  state_nxt = MC;
              end
              MC: begin
                if (inv) begin
                  state_nxt = SR;
                  round_nxt = round - ROUND_W'(1);
                end else begin
                  state_nxt = ARK;
                end
              end
              ARK: begin
                if (inv) begin
                  if (round == '0) begin
                    state_nxt = DONE;
                  end else if (round == nr) begin
                    state_nxt = SR;
                    round_nxt = round - ROUND_W'(1);
                  end else begin
                    state_nxt = MC;
                  end
                end else if (round == nr) begin
                  state_nxt = DONE;
                  round_nxt = '0;
                end else begin
                  state_nxt = SB;
                  round_nxt = round + ROUND_W'(1);
                end
              end
              default: state_nxt = IDLE;
            endcase
          end else if (TIMEOUT > 0) begin
            if (wd_cnt == WD_LAST) begin
              state_nxt  = ERROR;
              error_nxt  = 1'b1;
              wd_cnt_nxt = '0;
            end else begin
              wd_cnt_nxt = wd_cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wd_cnt <= '0;
      round  <= '0;
      nr     <= ROUND_W'(10);
      inv    <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= wd_cnt_nxt;
      round  <= round_nxt;
      nr     <= nr_nxt;
      inv    <= inv_nxt;
      error  <= error_nxt;
    end
  end

  assign bus.keyexp_enable = (state == KEYEXP);
  assign bus.sbytes_enable = (state == SB);
  assign bus.srows_enable  = (state == SR);
  assign bus.mcol_enable   = (state == MC);
  assign bus.around_enable = (state == ARK);
  assign bus.busy          = (state == KEYEXP) || (state == SB) || (state == SR) ||
                             (state == MC) || (state == ARK);
  assign bus.done          = (state == DONE);
  assign bus.error         = error;
  assign bus.inv           = inv;
  assign bus.roundnum      = round;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: directed and randomized operations checked against
// an expected step list built from the AES round ordering rules.
module tb_aes_round_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_round_sequencer_if #(.ROUND_W(4)) bus_a ();
  aes_round_sequencer_if #(.ROUND_W(4)) bus_b ();

  aes_round_sequencer #(.ROUND_W(4), .SUPPORT_256(1'b1), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );
  aes_round_sequencer #(.ROUND_W(4), .SUPPORT_256(1'b0), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  localparam int KE = 0, SBY = 1, SRO = 2, MCO = 3, ARK = 4, NONE = -1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // {enables KE,SB,SR,MC,ARK, busy, done, error, inv, roundnum}
  function automatic logic [15:0] expv(input int unit, input logic b, input logic d,
                                       input logic e, input logic iv, input logic [3:0] rn);
    logic [4:0] en;
    en = 5'b00000;
    if (unit >= 0) en = 5'b10000 >> unit;
    return {3'b000, en, b, d, e, iv, rn};
  endfunction

  function automatic logic [15:0] obs_a();
    return {3'b000, bus_a.keyexp_enable, bus_a.sbytes_enable, bus_a.srows_enable,
            bus_a.mcol_enable, bus_a.around_enable, bus_a.busy, bus_a.done,
            bus_a.error, bus_a.inv, bus_a.roundnum};
  endfunction

  function automatic logic [15:0] obs_b();
    return {3'b000, bus_b.keyexp_enable, bus_b.sbytes_enable, bus_b.srows_enable,
            bus_b.mcol_enable, bus_b.around_enable, bus_b.busy, bus_b.done,
            bus_b.error, bus_b.inv, bus_b.roundnum};
  endfunction

  task automatic set_fin_a(input logic [4:0] f);
    bus_a.keyexp_finished = f[4];
    bus_a.sbytes_finished = f[3];
    bus_a.srows_finished  = f[2];
    bus_a.mcol_finished   = f[1];
    bus_a.around_finished = f[0];
  endtask

  // One operation on dut_a. maxd: max finished delay per step; stray: random foreign
  // finished flags and busy-time start/mode noise; abort_rn >= 0 aborts at SB of that round.
  task automatic run_op(input int mode, input bit dec, input int maxd, input bit stray,
                        input int abort_rn);
    int unit_q[$];
    int rn_q[$];
    int nr;
    int k;
    logic [4:0] f;
    nr = 10 + 2 * mode;
    unit_q.push_back(KE); rn_q.push_back(0);
    if (!dec) begin
      unit_q.push_back(ARK); rn_q.push_back(0);
      for (int r = 1; r <= nr; r++) begin
        unit_q.push_back(SBY); rn_q.push_back(r);
        unit_q.push_back(SRO); rn_q.push_back(r);
        if (r != nr) begin unit_q.push_back(MCO); rn_q.push_back(r); end
        unit_q.push_back(ARK); rn_q.push_back(r);
      end
    end else begin
      unit_q.push_back(ARK); rn_q.push_back(nr);
      for (int r = nr - 1; r >= 0; r--) begin
        unit_q.push_back(SRO); rn_q.push_back(r);
        unit_q.push_back(SBY); rn_q.push_back(r);
        unit_q.push_back(ARK); rn_q.push_back(r);
        if (r != 0) begin unit_q.push_back(MCO); rn_q.push_back(r); end
      end
    end

    @(negedge clk);
    bus_a.key_mode = 2'(mode);
    bus_a.decrypt  = dec;
    bus_a.start    = 1'b1;
    set_fin_a(5'b00000);
    @(negedge clk);
    bus_a.start = 1'b0;
    for (int i = 0; i < unit_q.size(); i++) begin
      k = (maxd > 0) ? int'($urandom_range(maxd, 0)) : 0;
      for (int j = 0; j <= k; j++) begin
        check($sformatf("step%0d_u%0d_r%0d", i, unit_q[i], rn_q[i]), obs_a(),
              expv(unit_q[i], 1'b1, 1'b0, 1'b0, dec, 4'(rn_q[i])));
        if (abort_rn >= 0 && unit_q[i] == SBY && rn_q[i] == abort_rn) begin
          bus_a.abort = 1'b1;
          set_fin_a(5'b11111);
          @(negedge clk);
          bus_a.abort = 1'b0;
          set_fin_a(5'b00000);
          for (int c = 0; c < 3; c++) begin
            check("abort_idle", obs_a(), expv(NONE, 1'b0, 1'b0, 1'b0, dec, 4'd0));
            @(negedge clk);
          end
          return;
        end
        f = stray ? 5'($urandom) : 5'b00000;
        f[4 - unit_q[i]] = (j == k);
        set_fin_a(f);
        if (stray) begin
          bus_a.start    = 1'($urandom);
          bus_a.key_mode = 2'($urandom);
          bus_a.decrypt  = 1'($urandom);
        end
        @(negedge clk);
      end
    end
    bus_a.start = 1'b0;
    set_fin_a(5'b00000);
    check("done_pulse", obs_a(), expv(NONE, 1'b0, 1'b1, 1'b0, dec, 4'd0));
    @(negedge clk);
    check("after_done", obs_a(), expv(NONE, 1'b0, 1'b0, 1'b0, dec, 4'd0));
  endtask

  initial begin
    int cyc;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.key_mode = 2'b00; bus_a.decrypt = 1'b0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.key_mode = 2'b00; bus_b.decrypt = 1'b0;
    bus_b.keyexp_finished = 1'b0; bus_b.sbytes_finished = 1'b1; bus_b.srows_finished = 1'b1;
    bus_b.mcol_finished = 1'b1; bus_b.around_finished = 1'b1;
    set_fin_a(5'b00000);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_a", obs_a(), 32'h0);
    check("reset_b", obs_b(), 32'h0);
    rst = 1'b0;

    run_op(0, 1'b0, 0, 1'b0, -1);
    run_op(2, 1'b1, 0, 1'b0, -1);
    for (int n = 0; n < 6; n++)
      run_op(int'($urandom_range(2, 0)), 1'($urandom), 2, 1'b1, -1);

    // Watchdog expiry, then restart from ERROR.
    @(negedge clk);
    bus_a.key_mode = 2'b00; bus_a.decrypt = 1'b0; bus_a.start = 1'b1;
    set_fin_a(5'b00000);
    @(negedge clk);
    bus_a.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("wd_en%0d", c), obs_a(), expv(KE, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
      @(negedge clk);
    end
    check("wd_error", obs_a(), expv(NONE, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
    @(negedge clk);
    check("wd_sticky", obs_a(), expv(NONE, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    check("wd_restart", obs_a(), expv(KE, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    check("wd_abort", obs_a(), expv(NONE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));

    // Finished arriving in the final watchdog cycle wins.
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("wd_edge%0d", c), obs_a(), expv(KE, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
      if (c == 4) set_fin_a(5'b10000);
      @(negedge clk);
    end
    set_fin_a(5'b00000);
    check("wd_edge_adv", obs_a(), expv(ARK, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;

    // Invalid mode, then abort clears the sticky error.
    bus_a.key_mode = 2'b11; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    check("inv_mode", obs_a(), expv(NONE, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
    @(negedge clk);
    check("inv_mode_hold", obs_a(), expv(NONE, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    check("abort_clr", obs_a(), expv(NONE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));

    run_op(0, 1'b0, 0, 1'b0, 5);

    // Asynchronous reset while MixColumns is running.
    @(negedge clk);
    bus_a.key_mode = 2'b00; bus_a.decrypt = 1'b0; bus_a.start = 1'b1;
    set_fin_a(5'b11111);
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_mc", obs_a(), expv(MCO, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1));
    #2 rst = 1'b1;
    #1 check("async_rst", obs_a(), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    set_fin_a(5'b00000);
    check("post_rst", obs_a(), 32'h0);

    // No AES-256 on dut_b; a slow key expansion there has no watchdog.
    @(negedge clk);
    bus_b.key_mode = 2'b10; bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    check("b_no256", obs_b(), expv(NONE, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
    bus_b.key_mode = 2'b00; bus_b.decrypt = 1'b1; bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    for (cyc = 1; cyc <= 100; cyc++) begin
      if (bus_b.done) break;
      if (cyc == 11) bus_b.keyexp_finished = 1'b1;
      @(negedge clk);
    end
    check("b_done_cycle", cyc, 52);
    check("b_done_state", obs_b(), expv(NONE, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
